// File: rtl/conv_accum_out.sv
// Purpose : 3x3 convolution output stage. Accumulates TAPS signed pixel*weight products on top of a
//           per-window bias, then applies shift, optional ReLU and saturation to OUT_W bits.
// Latency : result presented (out_valid) one cycle after the last tap of a window is accepted.
// Backpr. : in_ready drops while a result is pending; the result is held until out_valid & out_ready.
// Ports   : clk/rst (sync, active-high) | clr aborts the current window (ignored while a result is pending)
//           in_valid/in_ready/pixel/weight/bias/relu_en : tap input, bias and relu_en sampled on first tap
//           out_valid/out_ready/out_data/out_sat : result output | busy : window in progress or result pending
module conv_accum_out #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int TAPS   = 9,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);
  // Signed OUT_W range expressed at accumulator width for the clamp compare.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      relu_q, relu_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [2*DATA_W-1:0] px_ext, wt_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, acc_base, acc_sum, shifted, rect;
  logic                       relu_sel, first_tap;
  logic signed [OUT_W-1:0]    res_data;
  logic                       res_sat;

  assign first_tap = (cnt_q == '0);

  // Datapath: product, running sum and the finished-result formatting. The
  // result is computed from the sum being loaded on the last tap so it can be
  // registered at the same edge as the state change.
  always_comb begin
    px_ext   = {{DATA_W{pixel[DATA_W-1]}}, pixel};
    wt_ext   = {{DATA_W{weight[DATA_W-1]}}, weight};
    prod     = px_ext * wt_ext;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_base = first_tap ? bias : acc_q;
    acc_sum  = acc_base + prod_ext;          // wraps modulo 2^ACC_W
    shifted  = acc_sum >>> SHIFT;
    // A one-tap window has its first and last tap on the same edge.
    relu_sel = first_tap ? relu_en : relu_q;
    rect     = (relu_sel && shifted[ACC_W-1]) ? '0 : shifted;
    res_data = rect[OUT_W-1:0];
    res_sat  = 1'b0;
    if (rect > OUT_MAX) begin
      res_data = OUT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (rect < OUT_MIN) begin
      res_data = OUT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_ACCUM: begin
        if (clr) begin
          cnt_d = '0;                        // any tap in this cycle is dropped
        end else if (in_valid) begin
          acc_d = acc_sum;
          if (first_tap) relu_d = relu_en;
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            state_d    = ST_OUTPUT;
            out_data_d = res_data;
            out_sat_d  = res_sat;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        // clr is deliberately ignored here so a finished result is never lost.
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      acc_q      <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // All outputs come straight from registered state.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (cnt_q != '0) || (state_q == ST_OUTPUT);

endmodule

// File: tb/tb_conv_accum_out.sv
module tb_conv_accum_out;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int TAPS   = 9;
  localparam int SHIFT  = 0;
  localparam int OUT_W  = 8;

  logic clk = 1'b0;
  logic rst, clr, in_valid, in_ready, relu_en, out_valid, out_ready, out_sat, busy;
  logic signed [DATA_W-1:0] pixel, weight;
  logic signed [ACC_W-1:0]  bias;
  logic signed [OUT_W-1:0]  out_data;

  conv_accum_out #(.DATA_W(DATA_W), .ACC_W(ACC_W), .TAPS(TAPS), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .pixel(pixel), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit bp_en  = 1'b0;

  typedef struct {
    longint d;
    longint s;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: whole-window sum wrapped to ACC_W, shifted, rectified, clamped.
  function automatic void ref_result(input longint s, input bit relu, output longint d, output longint sat);
    longint m, r, mx, mn;
    m  = longint'(1) <<< ACC_W;
    r  = s % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    r  = r >>> SHIFT;
    if (relu && r < 0) r = 0;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -(longint'(1) <<< (OUT_W - 1));
    if (r > mx) begin d = mx; sat = 1; end
    else if (r < mn) begin d = mn; sat = 1; end
    else begin d = r; sat = 0; end
  endfunction

  // Random backpressure on the result side.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 99) < 70);
  end

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  bit     stall = 1'b0;
  longint held_d, held_s;
  exp_t   e;
  always @(negedge clk) begin
    if (stall && out_valid) begin
      chk("hold_data", out_data, held_d);
      chk("hold_sat", out_sat, held_s);
    end
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) fail_now("unexpected_result");
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sat", out_sat, e.s);
      end
    end
    stall  = out_valid && !out_ready;
    held_d = out_data;
    held_s = out_sat;
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tap(input int p, input int w, input int b, input bit r, input bit last);
    int t = 0;
    bit got = 1'b0;
    in_valid = 1'b1;
    pixel    = DATA_W'(p);
    weight   = DATA_W'(w);
    bias     = ACC_W'(b);
    relu_en  = r;
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      idle();
      t++;
      if (!got && t > 200) begin
        fail_now("tap_accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
    if (last && got) begin
      @(negedge clk);
      chk("latency_out_valid", out_valid, 1);
      chk("in_ready_in_output", in_ready, 0);
      idle();
    end
  endtask

  task automatic window(input int b, input bit relu, input int pf, input int wf, input bit rnd,
                        input int gap_pct, input bit use_exp, input longint ed, input longint es);
    longint s = b;
    longint d, sat;
    int p, w;
    for (int i = 0; i < TAPS; i++) begin
      p = rnd ? int'($urandom_range(0, 255)) - 128 : pf;
      w = rnd ? int'($urandom_range(0, 255)) - 128 : wf;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        pixel = DATA_W'($urandom);
        idle();
      end
      s += longint'(p * w);
      if (i == TAPS - 1) begin
        if (use_exp) begin d = ed; sat = es; end
        else ref_result(s, relu, d, sat);
        sb.push_back('{d, sat});
      end
      // Bias and relu_en are scrambled on later taps: only the first tap counts.
      send_tap(p, w, (i == 0) ? b : int'($urandom_range(0, 2000)) - 1000,
               (i == 0) ? relu : 1'($urandom_range(0, 1)), i == TAPS - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; pixel = '0; weight = '0;
    bias = '0; relu_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    idle();

    // Directed windows with hand-derived results.
    window(0, 0, 1, 1, 0, 0, 1, 9, 0);
    window(0, 0, -10, 10, 0, 0, 1, -128, 1);
    window(0, 1, -10, 10, 0, 0, 1, 0, 0);
    window(5, 0, 2, 3, 0, 0, 1, 59, 0);
    window(5, 0, 2, 3, 0, 50, 1, 59, 0);
    window(-20, 1, 1, 1, 0, 0, 1, 0, 0);
    window(100, 0, 5, 5, 0, 0, 1, 127, 1);
    window(524287, 0, 1, 1, 0, 0, 1, -128, 1);   // sum wraps negative

    // Stalled result: held, in_ready low, clr ignored, then one handshake.
    out_ready = 1'b0;
    window(0, 0, 1, 1, 0, 0, 1, 9, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    idle();
    clr = 1'b1;
    idle();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_in_output_kept", out_valid, 1);
    idle();
    out_ready = 1'b1;
    idle();
    @(negedge clk);
    chk("after_hs_out_valid", out_valid, 0);
    chk("after_hs_in_ready", in_ready, 1);
    idle();

    // clr mid-window: aborted window yields nothing, a tap presented with clr is dropped.
    for (int i = 0; i < 4; i++) send_tap(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("busy_mid_window", busy, 1);
    idle();
    clr = 1'b1; in_valid = 1'b1; pixel = 8'sd50; weight = 8'sd50;
    idle();
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_clr", busy, 0);
    idle();
    window(0, 0, 1, 1, 0, 0, 1, 9, 0);

    // rst mid-window.
    for (int i = 0; i < 4; i++) send_tap(1, 1, 0, 0, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", busy, 0);
    idle();
    window(0, 0, 1, 1, 0, 0, 1, 9, 0);

    // rst with a result pending drops it.
    out_ready = 1'b0;
    window(0, 0, 2, 2, 0, 0, 1, 36, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("rst_output_valid", out_valid, 0);
    chk("rst_output_in_ready", in_ready, 1);
    chk("rst_output_busy", busy, 0);
    idle();
    out_ready = 1'b1;
    window(0, 0, 1, 1, 0, 0, 1, 9, 0);

    // Randomized windows against the reference model.
    bp_en = 1'b1;
    for (int n = 0; n < 40; n++)
      window(int'($urandom_range(0, 2047)) - 1024, 1'($urandom_range(0, 1)), 0, 0, 1, 30, 0, 0, 0);
    bp_en = 1'b0;
    out_ready = 1'b1;

    t = 0;
    while (sb.size() != 0 && t < 500) begin
      idle();
      t++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
